// File: rtl/s4ga_cfg_loader.sv
// Configuration sequencer for the S4GA serial LUT fabric: unpacks bitstream bytes into
// SI_W-bit words, shifts them in under fabric reset, settles, then releases the fabric.
`timescale 1ns/1ps
module s4ga_cfg_loader #(
  parameter int unsigned SI_W      = 4,
  parameter int unsigned CFG_WORDS = 128,
  parameter int unsigned SETTLE    = 2
) (
  input  logic                               i_clk,
  input  logic                               i_rst_n,
  input  logic                               i_start,
  input  logic                               i_abort,
  input  logic [7:0]                         i_in_data,
  input  logic                               i_in_valid,
  output logic                               o_in_ready,
  output logic [SI_W-1:0]                    o_fab_si,
  output logic                               o_fab_clk_en,
  output logic                               o_fab_rst,
  output logic                               o_busy,
  output logic                               o_done,
  output logic [$clog2(CFG_WORDS+1)-1:0]     o_word_cnt
);

  localparam int unsigned SUB   = 8 / SI_W;
  localparam int unsigned BYTES = CFG_WORDS * SI_W / 8;
  localparam int unsigned CW    = $clog2(CFG_WORDS + 1);
  localparam int unsigned BW    = $clog2(BYTES + 1);
  localparam int unsigned SW    = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  if (!(SI_W == 1 || SI_W == 2 || SI_W == 4 || SI_W == 8)) begin : g_bad_si_w
    $error("s4ga_cfg_loader: SI_W must be 1, 2, 4 or 8");
  end
  if ((CFG_WORDS * SI_W) % 8 != 0) begin : g_bad_cfg_words
    $error("s4ga_cfg_loader: CFG_WORDS*SI_W must be a multiple of 8");
  end
  if (SETTLE < 1) begin : g_bad_settle
    $error("s4ga_cfg_loader: SETTLE must be at least 1");
  end

  typedef enum logic [1:0] {StIdle, StLoad, StSettle, StRun} state_e;

  state_e          r_state, w_state_d;
  logic [7:0]      r_buf, w_buf_d;
  logic            r_full, w_full_d;
  logic [2:0]      r_idx, w_idx_d;
  logic [BW-1:0]   r_byte_cnt, w_byte_cnt_d;
  logic [SW-1:0]   r_settle, w_settle_d;
  logic            r_in_ready, w_in_ready_d;
  logic [SI_W-1:0] r_fab_si, w_fab_si_d;
  logic            r_clk_en, w_clk_en_d;
  logic            r_fab_rst, w_fab_rst_d;
  logic            r_busy, w_busy_d;
  logic            r_done, w_done_d;
  logic [CW-1:0]   r_word_cnt, w_word_cnt_d;

  logic            w_accept;
  logic            w_last;
  logic [SI_W-1:0] w_next_word;

  assign w_accept    = r_in_ready & i_in_valid;
  assign w_last      = r_full && (r_idx == 3'(SUB - 1));
  assign w_next_word = SI_W'(r_buf >> (SI_W * (32'(r_idx) + 32'd1)));

  always_comb begin
    w_state_d    = r_state;
    w_buf_d      = r_buf;
    w_full_d     = r_full;
    w_idx_d      = r_idx;
    w_byte_cnt_d = r_byte_cnt;
    w_settle_d   = r_settle;
    w_fab_si_d   = r_fab_si;
    w_word_cnt_d = r_word_cnt;

    unique case (r_state)
      StIdle, StRun: begin
        if (i_start) begin
          w_state_d    = StLoad;
          w_word_cnt_d = '0;
          w_byte_cnt_d = '0;
          w_full_d     = 1'b0;
          w_idx_d      = '0;
        end
      end
      StLoad: begin
        if (i_abort) begin
          w_state_d = StIdle;
          w_full_d  = 1'b0;
        end else begin
          if (r_full) w_word_cnt_d = r_word_cnt + 1'b1;
          // The word on fab_si this cycle is the last one of the image.
          if (r_full && r_word_cnt == CW'(CFG_WORDS - 1)) begin
            w_state_d  = StSettle;
            w_full_d   = 1'b0;
            w_settle_d = '0;
            w_fab_si_d = '0;
          end else if (w_accept) begin
            w_buf_d      = i_in_data;
            w_full_d     = 1'b1;
            w_idx_d      = '0;
            w_byte_cnt_d = r_byte_cnt + 1'b1;
            w_fab_si_d   = i_in_data[SI_W-1:0];
          end else if (r_full && !w_last) begin
            w_idx_d    = r_idx + 3'd1;
            w_fab_si_d = w_next_word;
          end else if (w_last) begin
            w_full_d = 1'b0;
          end
        end
      end
      StSettle: begin
        if (i_abort) begin
          w_state_d = StIdle;
        end else if (r_settle == SW'(SETTLE - 1)) begin
          w_state_d = StRun;
        end else begin
          w_settle_d = r_settle + 1'b1;
        end
      end
      default: w_state_d = StIdle;
    endcase

    // Outputs are registered, so they are derived from the next state.
    w_in_ready_d = (w_state_d == StLoad) && (!w_full_d || w_idx_d == 3'(SUB - 1)) &&
                   (w_byte_cnt_d < BW'(BYTES));
    w_clk_en_d   = ((w_state_d == StLoad) && w_full_d) || (w_state_d == StSettle) ||
                   (w_state_d == StRun);
    w_fab_rst_d  = (w_state_d != StRun);
    w_busy_d     = (w_state_d == StLoad) || (w_state_d == StSettle);
    w_done_d     = (w_state_d == StRun);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= StIdle;
      r_buf      <= '0;
      r_full     <= 1'b0;
      r_idx      <= '0;
      r_byte_cnt <= '0;
      r_settle   <= '0;
      r_in_ready <= 1'b0;
      r_fab_si   <= '0;
      r_clk_en   <= 1'b0;
      r_fab_rst  <= 1'b1;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_word_cnt <= '0;
    end else begin
      r_state    <= w_state_d;
      r_buf      <= w_buf_d;
      r_full     <= w_full_d;
      r_idx      <= w_idx_d;
      r_byte_cnt <= w_byte_cnt_d;
      r_settle   <= w_settle_d;
      r_in_ready <= w_in_ready_d;
      r_fab_si   <= w_fab_si_d;
      r_clk_en   <= w_clk_en_d;
      r_fab_rst  <= w_fab_rst_d;
      r_busy     <= w_busy_d;
      r_done     <= w_done_d;
      r_word_cnt <= w_word_cnt_d;
    end
  end

  assign o_in_ready   = r_in_ready;
  assign o_fab_si     = r_fab_si;
  assign o_fab_clk_en = r_clk_en;
  assign o_fab_rst    = r_fab_rst;
  assign o_busy       = r_busy;
  assign o_done       = r_done;
  assign o_word_cnt   = r_word_cnt;

endmodule

// File: doc/s4ga_cfg_loader.md
Name: s4ga_cfg_loader

Overview:
Configuration sequencer for the S4GA serial LUT fabric. Accepts the fabric bitstream as bytes over a valid/ready stream and splits each byte into SI_W-bit words. Drives those words into the fabric's serial config input while holding the fabric in reset. Gates the fabric clock so no word is shifted during host stalls, then releases the fabric to run once the full image is loaded.

Parameters:
SI_W, 4, fabric serial-input width. Legal values are 1, 2, 4 and 8; any other value is an elaboration error.
CFG_WORDS, 128, SI_W-bit words per full image (N=16, K=4 image). CFG_WORDS*SI_W must be a multiple of 8.
SETTLE, 2, fabric clocks with reset still asserted after the last word, before release (≥1).

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  reset, asynchronous, active-low (0 = reset).
start  in  1  single-cycle pulse; begins a (re)configuration.
abort  in  1  single-cycle pulse; cancels an in-progress load.
in_data  in  8  bitstream byte.
in_valid  in  1  in_data valid.
in_ready  out  1  loader accepts in_data this cycle.
fab_si  out  SI_W  serial config word to fabric.
fab_clk_en  out  1  fabric clock enable; 1 = fabric advances this cycle.
fab_rst  out  1  fabric reset, active-high.
busy  out  1  high in LOAD or SETTLE.
done  out  1  high in RUN.
word_cnt  out  $clog2(CFG_WORDS+1)  words delivered in the current load.

Behaviour:
- States: IDLE, LOAD, SETTLE, RUN. All outputs are registered.
- Reset (rst=0, any state, takes effect immediately):
  - state=IDLE, in_ready=0, fab_si=0, fab_clk_en=0, fab_rst=1, busy=0, done=0, word_cnt=0.
  - Byte buffer is emptied.
- IDLE: fab_rst=1, fab_clk_en=0.
  - start -> LOAD; word_cnt cleared.
  - abort is ignored.
- LOAD:
  - fab_rst=1. Holds a one-byte buffer plus a sub-word index 0..8/SI_W-1.
  - in_ready=1 when:
    - the buffer is empty, or its last word is emitted this cycle; and
    - fewer than CFG_WORDS*SI_W/8 bytes have been accepted.
  - A transfer happens on in_valid & in_ready.
  - Word order within a byte is LSB-first: byte 0xA5 with SI_W=4 gives fab_si=0x5, then 0xA.
  - Latency: byte accepted at edge t -> first word on fab_si with fab_clk_en=1 in cycle t+1.
  - Sustained throughput: one byte per 8/SI_W cycles, with no gaps when in_valid is held high.
  - Buffer empty: fab_clk_en=0 and fab_si holds its last value. Stalls are unbounded.
  - word_cnt increments on each cycle with fab_clk_en=1.
  - Once word_cnt reaches CFG_WORDS, the next cycle -> SETTLE.
  - abort -> IDLE: buffer dropped, fab_clk_en=0, word_cnt unchanged for debug.
  - start is ignored.
- SETTLE: fab_rst=1, fab_clk_en=1, fab_si=0, in_ready=0.
  - After exactly SETTLE cycles -> RUN.
  - abort -> IDLE; start is ignored.
- RUN: fab_rst=0, fab_clk_en=1, done=1, in_ready=0.
  - start -> LOAD: fab_rst reasserts the same cycle as the LOAD entry, done=0, word_cnt=0.
  - abort is ignored.
- Simultaneous start and abort: abort wins in LOAD/SETTLE; start wins in IDLE/RUN.
- Extra bytes: no byte is accepted beyond the image length. in_valid with in_ready=0 is not a transfer; the host holds data.
- Protocol:
  - in_ready must not depend combinationally on in_valid.
  - fab_si is meaningful only when fab_clk_en=1 and fab_rst=1.

Test Plan:
- Reset, then start; stream bytes 0x00..0x3F with in_valid held high. Required: 128 consecutive cycles with fab_clk_en=1; fab_si sequence 0,0,1,0,2,0,…,F,3; word_cnt reaches 128; then 2 SETTLE cycles; then fab_rst=0 and done=1.
- Byte 0xA5 as the first byte. Required: fab_si=0x5 at t+1 and 0xA at t+2, where t is the accept edge.
- Drop in_valid for 5 cycles after byte 10. Required: fab_clk_en=0 for those cycles, fab_si and word_cnt frozen, then resume with no word lost or duplicated.
- abort at word_cnt=37. Required: IDLE next cycle, in_ready=0, fab_rst=1, fab_clk_en=0, word_cnt=37; a new start restarts from 0.
- rst=0 mid-LOAD, asynchronous between edges. Required: all outputs at reset values immediately; no fab_clk_en pulse after release until start.
- In RUN, pulse start together with abort. Required: LOAD entered, done=0, fab_rst=1, full reload completes. A start pulse during LOAD has no effect.
